param_pipe_datapath: RTL and testbench

- Parametrised successor to the fixed 32-bit MIPS 5-stage datapath: a single-issue, in-order execute/memory/writeback pipeline with configurable data width, register count and result-pipeline depth.
- Includes full forwarding from every in-flight stage and a load-use interlock.
- Sits between the decoder/issue logic and the data-memory port, and owns the general-purpose register file.

---
 rtl/param_pipe_datapath.sv | 187 ++++++++++++++++++
 tb/tb_param_pipe_datapath.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_pipe_datapath.sv
// Parametrised in-order execute/memory/writeback pipeline that owns the register file.
// Optional macro PDP_FWD_EN enables bypassing; without it, hazards stall until the producer commits.
module param_pipe_datapath #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int EX_DEPTH = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [REG_AW-1:0] iss_rs,
   input  logic [REG_AW-1:0] iss_rt,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              iss_wen,
   input  logic [2:0]        iss_op,
   input  logic              iss_use_imm,
   input  logic [DATA_W-1:0] iss_imm,
   input  logic              iss_load,
   input  logic              iss_store,
   input  logic              flush,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int SHW  = $clog2(DATA_W);
   localparam int NREG = 2**REG_AW;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_PASSB
   } op_e;

   typedef struct packed {
      logic              wen;
      logic [REG_AW-1:0] rd;
      logic              load;
      logic              store;
      op_e               op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] sd;
   } p1_t;

   typedef struct packed {
      logic              wen;
      logic [REG_AW-1:0] rd;
      logic              load;
      logic [DATA_W-1:0] result;
   } pk_t;

   logic [EX_DEPTH:1]  vld_pipe;
   p1_t                p1, p1_nxt;
   pk_t                stg    [2:EX_DEPTH];
   logic [DATA_W-1:0]  rf     [NREG];
   logic [DATA_W-1:0]  res    [1:EX_DEPTH];
   logic [EX_DEPTH:1]  st_wen;
   logic [REG_AW-1:0]  st_rd  [1:EX_DEPTH];
   logic [DATA_W-1:0]  alu, rf_a, rf_b, opa, rtv;
   logic               hazard, accept, commit, rt_used;

   // Per-stage view used by forwarding and hazard detection; a load in p2
   // takes its result straight from the memory port.
   always_comb begin
      res[1]    = alu;
      st_wen[1] = p1.wen;
      st_rd[1]  = p1.rd;
      for (int k = 2; k <= EX_DEPTH; k++) begin
         res[k]    = stg[k].result;
         st_wen[k] = stg[k].wen;
         st_rd[k]  = stg[k].rd;
      end
      if (stg[2].load) res[2] = mem_rdata;
   end

   always_comb begin
      alu = p1.b;
      case (p1.op)
         OP_ADD:   alu = p1.a + p1.b;
         OP_SUB:   alu = p1.a - p1.b;
         OP_AND:   alu = p1.a & p1.b;
         OP_OR:    alu = p1.a | p1.b;
         OP_XOR:   alu = p1.a ^ p1.b;
         OP_SLT:   alu = {{(DATA_W-1){1'b0}}, ($signed(p1.a) < $signed(p1.b))};
         OP_SLL:   alu = p1.a << p1.b[SHW-1:0];
         OP_PASSB: alu = p1.b;
         default:  alu = p1.b;
      endcase
   end

   assign commit   = vld_pipe[EX_DEPTH] & stg[EX_DEPTH].wen & (stg[EX_DEPTH].rd != '0);
   assign wb_valid = commit;
   assign wb_addr  = stg[EX_DEPTH].rd;
   assign wb_data  = res[EX_DEPTH];
   assign dbg_data = rf[dbg_addr];

   // Register file read with write-through of the commit happening this cycle.
   always_comb begin
      rf_a = rf[iss_rs];
      rf_b = rf[iss_rt];
      if (commit && wb_addr == iss_rs) rf_a = wb_data;
      if (commit && wb_addr == iss_rt) rf_b = wb_data;
      if (iss_rs == '0) rf_a = '0;
      if (iss_rt == '0) rf_b = '0;
   end

   assign rt_used = ~iss_use_imm | iss_store;

`ifdef PDP_FWD_EN
   // Walk oldest to youngest so the youngest matching producer wins.
   always_comb begin
      opa = rf_a;
      rtv = rf_b;
      for (int k = EX_DEPTH; k >= 1; k--) begin
         if (vld_pipe[k] && st_wen[k] && iss_rs != '0 && st_rd[k] == iss_rs) opa = res[k];
         if (vld_pipe[k] && st_wen[k] && iss_rt != '0 && st_rd[k] == iss_rt) rtv = res[k];
      end
      hazard = vld_pipe[1] & p1.load & (p1.rd != '0) &
               ((p1.rd == iss_rs) | (rt_used & (p1.rd == iss_rt)));
   end
`else
   always_comb begin
      opa    = rf_a;
      rtv    = rf_b;
      hazard = 1'b0;
      for (int k = 1; k <= EX_DEPTH; k++) begin
         if (vld_pipe[k] && st_wen[k] && st_rd[k] != '0 &&
             (st_rd[k] == iss_rs || (rt_used && st_rd[k] == iss_rt)))
            hazard = 1'b1;
      end
   end
`endif

   assign iss_ready = rst_n & ~flush & ~hazard;
   assign accept    = iss_valid & iss_ready;

   // Memory ops always compute A + imm.
   always_comb begin
      p1_nxt       = '0;
      p1_nxt.wen   = iss_wen;
      p1_nxt.rd    = iss_rd;
      p1_nxt.load  = iss_load;
      p1_nxt.store = iss_store;
      p1_nxt.op    = (iss_load | iss_store) ? OP_ADD : op_e'(iss_op);
      p1_nxt.a     = opa;
      p1_nxt.b     = (iss_use_imm | iss_load | iss_store) ? iss_imm : rtv;
      p1_nxt.sd    = rtv;
   end

   assign mem_ren   = vld_pipe[1] & p1.load & ~flush;
   assign mem_wen   = vld_pipe[1] & p1.store & ~flush;
   assign mem_addr  = alu;
   assign mem_wdata = p1.sd;

   // Flush kills everything behind the committing stage; p1 is refilled by
   // issue only, so a stall simply inserts a bubble there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         p1       <= '0;
         for (int k = 2; k <= EX_DEPTH; k++) stg[k] <= '0;
      end else begin
         vld_pipe[1] <= accept;
         for (int k = 2; k <= EX_DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1] & ~flush;
         if (accept) p1 <= p1_nxt;
         stg[2] <= '{wen: p1.wen, rd: p1.rd, load: p1.load, result: alu};
         for (int k = 3; k <= EX_DEPTH; k++)
            stg[k] <= '{wen: stg[k-1].wen, rd: stg[k-1].rd, load: 1'b0, result: res[k-1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (commit) begin
         rf[wb_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_param_pipe_datapath.sv
// Directed bench for param_pipe_datapath (default parameters); stall expectations follow PDP_FWD_EN.
module tb_param_pipe_datapath;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef PDP_FWD_EN
   localparam int S1_EXP = 0;
   localparam int S3_EXP = 1;
`else
   localparam int S1_EXP = 3;
   localparam int S3_EXP = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          iss_valid, iss_ready, iss_wen, iss_use_imm, iss_load, iss_store, flush;
   logic [AW-1:0] iss_rs, iss_rt, iss_rd, wb_addr, dbg_addr;
   logic [2:0]    iss_op;
   logic [DW-1:0] iss_imm, mem_addr, mem_wdata, mem_rdata, wb_data, dbg_data;
   logic          mem_ren, mem_wen, wb_valid;

   param_pipe_datapath dut (
      .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd), .iss_wen(iss_wen),
      .iss_op(iss_op), .iss_use_imm(iss_use_imm), .iss_imm(iss_imm),
      .iss_load(iss_load), .iss_store(iss_store), .flush(flush),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            wen_cnt = 0;
   logic [DW-1:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;
   logic [DW-1:0] mem [0:255];
   logic [AW-1:0] log_addr [$];
   logic [DW-1:0] log_data [$];
   int            log_cyc  [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: store writes at the edge, load data appears one cycle after mem_ren.
   always @(posedge clk) begin
      if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_ren) mem_rdata <= mem[mem_addr[7:0]];
   end

   always @(negedge clk) begin
      if (wb_valid) begin
         log_addr.push_back(wb_addr);
         log_data.push_back(wb_data);
         log_cyc.push_back(cyc);
      end
      if (mem_wen) begin
         wen_cnt    <= wen_cnt + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
      if (mem_ren) last_raddr <= mem_addr;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      dbg_addr = a;
      @(negedge clk);
      chk(tag, dbg_data, exp);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present one op; hold it until accepted; must be called just after a posedge.
   task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic wen, input logic use_imm,
                        input logic [DW-1:0] imm, input logic ld, input logic st,
                        output int stalls);
      int n;
      stalls = 0;
      n = 0;
      iss_op = op; iss_rd = rd; iss_rs = rs; iss_rt = rt; iss_wen = wen;
      iss_use_imm = use_imm; iss_imm = imm; iss_load = ld; iss_store = st;
      iss_valid = 1'b1;
      @(negedge clk);
      while (!iss_ready && n < 20) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (!iss_ready) begin
         checks++;
         errors++;
         $error("FAIL issue_timeout: rd %0d never accepted", rd);
      end
      @(posedge clk);
      #1;
      iss_valid = 1'b0;
   endtask

   initial begin
      int s, base, w0;
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, base, w0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem_rdata = '0;
      rst_n = 1'b0; flush = 1'b0; dbg_addr = '0;
      iss_valid = 1'b0; iss_op = '0; iss_rd = '0; iss_rs = '0; iss_rt = '0;
      iss_wen = 1'b0; iss_use_imm = 1'b0; iss_imm = '0; iss_load = 1'b0; iss_store = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_iss_ready", iss_ready, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", iss_ready, 1);

      // Scenario 1: r1 = 0+5, r2 = r1+3 back-to-back
      sync();
      base = log_addr.size();
      issue(3'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, s);
      issue(3'd0, 5'd2, 5'd1, 5'd0, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, s);
      chk("s1_stalls", s, S1_EXP);
      repeat (8) @(negedge clk);
      chk("s1_ncommit", log_addr.size() - base, 2);
      chk("s1_c0_addr", log_addr[base], 1);
      chk("s1_c0_data", log_data[base], 5);
      chk("s1_c1_addr", log_addr[base+1], 2);
      chk("s1_c1_data", log_data[base+1], 8);
      chk("s1_c1_gap", log_cyc[base+1] - log_cyc[base], 1 + S1_EXP);
      chk_reg("s1_r2", 5'd2, 32'd8);

      // Scenario 2: ALU op coverage
      sync();
      issue(3'd7, 5'd3,  5'd0,  5'd0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, s);
      issue(3'd5, 5'd4,  5'd3,  5'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, s);
      issue(3'd6, 5'd10, 5'd3,  5'd0, 1'b1, 1'b1, 32'h1,         1'b0, 1'b0, s);
      issue(3'd1, 5'd11, 5'd0,  5'd0, 1'b1, 1'b1, 32'h1,         1'b0, 1'b0, s);
      issue(3'd4, 5'd12, 5'd2,  5'd0, 1'b1, 1'b1, 32'hF,         1'b0, 1'b0, s);
      issue(3'd3, 5'd16, 5'd1,  5'd0, 1'b1, 1'b1, 32'h10,        1'b0, 1'b0, s);
      issue(3'd2, 5'd17, 5'd11, 5'd0, 1'b1, 1'b1, 32'hF0F0,      1'b0, 1'b0, s);
      repeat (6) @(negedge clk);
      chk_reg("s2_passb", 5'd3,  32'h8000_0000);
      chk_reg("s2_slt",   5'd4,  32'h1);
      chk_reg("s2_sll",   5'd10, 32'h0);
      chk_reg("s2_sub",   5'd11, 32'hFFFF_FFFF);
      chk_reg("s2_xor",   5'd12, 32'h7);
      chk_reg("s2_or",    5'd16, 32'h15);
      chk_reg("s2_and",   5'd17, 32'hF0F0);

      // Scenario 3: store, load, load-use
      sync();
      w0 = wen_cnt;
      issue(3'd0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, s);
      issue(3'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, s);
      issue(3'd0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 32'h1,  1'b0, 1'b0, s);
      chk("s3_loaduse_stalls", s, S3_EXP);
      repeat (6) @(negedge clk);
      chk("s3_store_cnt", wen_cnt - w0, 1);
      chk("s3_store_addr", last_waddr, 32'h10);
      chk("s3_store_data", last_wdata, 32'h8);
      chk("s3_load_addr", last_raddr, 32'h10);
      chk_reg("s3_r5", 5'd5, 32'h8);
      chk_reg("s3_r6", 5'd6, 32'h9);

      // Scenario 4: flush with r7/r8/store in p3/p2/p1, r9 held during flush
      sync();
      w0 = wen_cnt;
      base = log_addr.size();
      issue(3'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 32'd7,  1'b0, 1'b0, s);
      issue(3'd0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 32'd8,  1'b0, 1'b0, s);
      issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, s);
      flush = 1'b1;
      iss_op = 3'd0; iss_rd = 5'd9; iss_rs = 5'd0; iss_rt = 5'd0; iss_wen = 1'b1;
      iss_use_imm = 1'b1; iss_imm = 32'd9; iss_load = 1'b0; iss_store = 1'b0; iss_valid = 1'b1;
      @(negedge clk);
      chk("s4_flush_ready", iss_ready, 0);
      chk("s4_flush_memwen", mem_wen, 0);
      chk("s4_flush_wbvalid", wb_valid, 1);
      chk("s4_flush_wbaddr", wb_addr, 7);
      @(posedge clk); #1; flush = 1'b0;
      issue(3'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9, 1'b0, 1'b0, s);
      repeat (6) @(negedge clk);
      chk("s4_no_store", wen_cnt - w0, 0);
      chk("s4_ncommit", log_addr.size() - base, 2);
      chk("s4_second_commit", log_addr[base+1], 9);
      chk_reg("s4_r7", 5'd7, 32'd7);
      chk_reg("s4_r8", 5'd8, 32'd0);
      chk_reg("s4_r9", 5'd9, 32'd9);

      // Scenario 5: write to r0 is dropped, r0 reads as zero
      sync();
      issue(3'd7, 5'd0,  5'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b0, s);
      issue(3'd0, 5'd18, 5'd0, 5'd0, 1'b1, 1'b1, 32'h40,   1'b0, 1'b0, s);
      @(negedge clk);
      @(negedge clk);
      chk("s5_r0_wbvalid", wb_valid, 0);
      @(negedge clk);
      chk("s5_r18_wbvalid", wb_valid, 1);
      chk("s5_r18_wbaddr", wb_addr, 18);
      chk("s5_r18_wbdata", wb_data, 32'h40);
      chk_reg("s5_dbg_r0", 5'd0, 32'h0);

      // Scenario 6: reset mid-sequence
      sync();
      issue(3'd0, 5'd13, 5'd0, 5'd0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, s);
      issue(3'd0, 5'd14, 5'd0, 5'd0, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0, s);
      base = log_addr.size();
      rst_n = 1'b0;
      dbg_addr = 5'd1;
      #1;
      chk("s6_ready", iss_ready, 0);
      chk("s6_wbvalid", wb_valid, 0);
      chk("s6_memren", mem_ren, 0);
      chk("s6_r1_cleared", dbg_data, 0);
      dbg_addr = 5'd6;
      #1;
      chk("s6_r6_cleared", dbg_data, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("s6_no_commit", log_addr.size() - base, 0);
      chk_reg("s6_r13", 5'd13, 32'h0);
      chk_reg("s6_r14", 5'd14, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
